drop_ctrl: RTL and testbench

- Move controller directly upstream of the board RAM / win-check stage (ramRW).
- Accepts a player's column choice, finds the lowest empty cell through the shared RAM port, and writes the current player's piece.
- Then raises winnerCheck, waits for wCheckComplete, and either hands the turn to the other player or parks in game-over.
- Also clears the board (addresses 7..48) after reset and on new-game.

---
 rtl/drop_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_drop_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_ctrl.sv
// drop_ctrl: move controller sitting in front of the board RAM / win-check
// stage. Clears the board, turns a column choice into a write of the current
// player's piece in the lowest empty cell, then hands off to the win check.
//
// Ports
//   clk, resetn      system clock, asynchronous active-low reset
//   col_sel, drop    column (0..6) and one-cycle drop request
//   new_game         one-cycle request to clear the board and restart
//   ram_q            RAM read data
//   check_complete   win-check done strobe; game_over qualifies it
//   ram_address      RAM address (probe / write / clear)
//   ram_data         RAM write data
//   ram_wren         RAM write enable
//   winner_check     win-check request, held until check_complete
//   reset_game       one-cycle pulse at the start of every board clear
//   player           player to move: 01 = P1, 10 = P2
//   busy             low only in IDLE and OVER
//   col_err          one-cycle pulse: invalid column or full column
//   move_count       pieces placed this game
//
// state | meaning
// CLEAR | write 00 to every board cell, first cycle only arms the sweep
// IDLE  | waiting for drop / new_game
// PROBE | read one cell of the chosen column, bottom row upwards
// WRITE | write the player's piece to the empty cell found
// CHECK | win-check request raised, waiting for check_complete
// OVER  | game finished, only new_game leaves

module drop_ctrl #(
  parameter int READ_WAIT = 3,
  parameter int BASE_ADDR = 7,
  parameter int ROWS      = 6,
  parameter int COLS      = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] col_sel,
  input  logic       drop,
  input  logic       new_game,
  input  logic [1:0] ram_q,
  input  logic       check_complete,
  input  logic       game_over,
  output logic [5:0] ram_address,
  output logic [1:0] ram_data,
  output logic       ram_wren,
  output logic       winner_check,
  output logic       reset_game,
  output logic [1:0] player,
  output logic       busy,
  output logic       col_err,
  output logic [5:0] move_count
);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_PROBE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int              WAIT_W    = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_WAIT);
  localparam logic [5:0]      FIRST_ADDR = 6'(BASE_ADDR);
  localparam logic [5:0]      LAST_ADDR  = 6'(BASE_ADDR + ROWS * COLS - 1);
  localparam logic [2:0]      BOT_ROW    = 3'(ROWS - 1);
  localparam logic [2:0]      MAX_COL    = 3'(COLS - 1);

  logic [2:0]        r_state;
  logic [5:0]        r_clr_addr;
  logic              r_clr_go;
  logic [2:0]        r_col;
  logic [2:0]        r_row;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_player;
  logic [5:0]        r_move_count;
  logic              r_col_err;
  logic              r_reset_game;
  logic [5:0]        w_probe_addr;

  assign w_probe_addr = 6'(BASE_ADDR + COLS * int'(r_row) + int'(r_col));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_CLEAR;
      r_clr_addr   <= FIRST_ADDR;
      r_clr_go     <= 1'b0;
      r_col        <= 3'd0;
      r_row        <= 3'd0;
      r_wait       <= '0;
      r_player     <= 2'b01;
      r_move_count <= 6'd0;
      r_col_err    <= 1'b0;
      r_reset_game <= 1'b0;
    end else begin
      r_col_err    <= 1'b0;
      r_reset_game <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          // The arming cycle keeps ram_wren low while reset is still fresh;
          // reset_game lines up with the first real clear write.
          if (!r_clr_go) begin
            r_clr_go     <= 1'b1;
            r_reset_game <= 1'b1;
          end else if (r_clr_addr == LAST_ADDR) begin
            r_clr_go   <= 1'b0;
            r_clr_addr <= FIRST_ADDR;
            r_state    <= S_IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + 6'd1;
          end
        end
        S_IDLE: begin
          if (new_game) begin
            r_player     <= 2'b01;
            r_move_count <= 6'd0;
            r_clr_addr   <= FIRST_ADDR;
            r_clr_go     <= 1'b0;
            r_state      <= S_CLEAR;
          end else if (drop) begin
            if (col_sel > MAX_COL) begin
              r_col_err <= 1'b1;
            end else begin
              r_col   <= col_sel;
              r_row   <= BOT_ROW;
              r_wait  <= WAIT_LOAD;
              r_state <= S_PROBE;
            end
          end
        end
        S_PROBE: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WAIT_W'(1);
          end else if (ram_q == 2'b00) begin
            r_state <= S_WRITE;
          end else if (r_row != 3'd0) begin
            r_row  <= r_row - 3'd1;
            r_wait <= WAIT_LOAD;
          end else begin
            r_col_err <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_WRITE: begin
          r_move_count <= r_move_count + 6'd1;
          r_state      <= S_CHECK;
        end
        S_CHECK: begin
          if (check_complete) begin
            if (game_over) begin
              r_state <= S_OVER;
            end else begin
              r_player <= ~r_player;
              r_state  <= S_IDLE;
            end
          end
        end
        S_OVER: begin
          if (new_game) begin
            r_player     <= 2'b01;
            r_move_count <= 6'd0;
            r_clr_addr   <= FIRST_ADDR;
            r_clr_go     <= 1'b0;
            r_state      <= S_CLEAR;
          end
        end
        default: begin
          r_clr_addr <= FIRST_ADDR;
          r_clr_go   <= 1'b0;
          r_state    <= S_CLEAR;
        end
      endcase
    end
  end

  // Decoded straight from state so winner_check and ram_wren fall the
  // moment reset is asserted, without waiting for a clock.
  assign ram_wren     = ((r_state == S_CLEAR) && r_clr_go) || (r_state == S_WRITE);
  assign ram_data     = (r_state == S_WRITE) ? r_player : 2'b00;
  assign ram_address  = (r_state == S_CLEAR) ? r_clr_addr : w_probe_addr;
  assign winner_check = (r_state == S_CHECK);
  assign busy         = (r_state != S_IDLE) && (r_state != S_OVER);
  assign reset_game   = r_reset_game;
  assign col_err      = r_col_err;
  assign player       = r_player;
  assign move_count   = r_move_count;

endmodule

// File: tb/tb_drop_ctrl.sv
module tb_drop_ctrl;

  localparam int RW = 3;
  localparam int K_RG = 0, K_WR = 1, K_PR = 2, K_ER = 3, K_WC = 4;

  typedef struct {
    int         kind;
    logic [5:0] addr;
    logic [1:0] data;
  } ev_t;

  logic       clk, resetn;
  logic [2:0] col_sel;
  logic       drop, new_game;
  logic [1:0] ram_q;
  logic       check_complete, game_over;
  logic [5:0] ram_address;
  logic [1:0] ram_data;
  logic       ram_wren, winner_check, reset_game, busy, col_err;
  logic [1:0] player;
  logic [5:0] move_count;

  drop_ctrl #(.READ_WAIT(RW), .BASE_ADDR(7), .ROWS(6), .COLS(7)) dut (
    .clk(clk), .resetn(resetn), .col_sel(col_sel), .drop(drop),
    .new_game(new_game), .ram_q(ram_q), .check_complete(check_complete),
    .game_over(game_over), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .winner_check(winner_check), .reset_game(reset_game),
    .player(player), .busy(busy), .col_err(col_err), .move_count(move_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ev_t exp_q[$];

  // RAM model: read data follows the address with RW cycles of latency
  logic [1:0] mem [0:63];
  logic [5:0] a1, a2, a3;
  logic       bd_en;
  logic [5:0] bd_addr;
  logic [1:0] bd_data;
  assign ram_q = mem[a3];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    a1  <= ram_address;
    a2  <= a1;
    a3  <= a2;
    if (ram_wren) mem[ram_address] <= ram_data;
    else if (bd_en) mem[bd_addr] <= bd_data;
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // win-check responder: completes on the third cycle of winner_check
  logic cc_enable, go_flag;
  initial begin
    int cnt;
    cnt = 0;
    check_complete = 0;
    game_over = 0;
    forever begin
      @(posedge clk);
      #1;
      check_complete = 0;
      game_over = 0;
      if (winner_check && resetn && cc_enable) begin
        cnt++;
        if (cnt == 3) begin
          check_complete = 1;
          game_over = go_flag;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic see(input int kind, input logic [5:0] a, input logic [1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d addr=%0d data=%0d required none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL event actual kind=%0d addr=%0d data=%0d required kind=%0d addr=%0d data=%0d",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic push(input int kind, input int a, input int d);
    ev_t e;
    e.kind = kind;
    e.addr = 6'(a);
    e.data = 2'(d);
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    push(K_RG, 0, 0);
    for (int a = 7; a <= 48; a++) push(K_WR, a, 0);
  endtask

  // monitor: turns DUT activity into events and checks them against exp_q
  int last_wr_cyc = -1, last_err_cyc = -1;
  int run = 0, wc_len = 0;
  logic [5:0] run_addr = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      run = 0;
      wc_len = 0;
    end else begin
      if (reset_game) see(K_RG, 0, 0);
      if (ram_wren) begin
        see(K_WR, ram_address, ram_data);
        last_wr_cyc = cyc;
      end
      if (busy && !ram_wren && !winner_check) begin
        if (run > 0 && ram_address == run_addr) run++;
        else begin
          run = 1;
          run_addr = ram_address;
        end
        if (run == RW + 1) see(K_PR, run_addr, 0);
      end else begin
        run = 0;
      end
      if (col_err) begin
        see(K_ER, 0, 0);
        last_err_cyc = cyc;
      end
      if (winner_check) wc_len++;
      else if (wc_len > 0) begin
        see(K_WC, 6'(wc_len), 0);
        wc_len = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 400) begin
      tick(1);
      k++;
    end
    chk({name, "_idle_timeout"}, int'(busy), 0);
    tick(2);
  endtask

  int t_drop;
  task automatic do_drop(input int c);
    @(posedge clk);
    #1;
    drop = 1;
    col_sel = 3'(c);
    t_drop = cyc;
    tick(1);
    drop = 0;
  endtask

  task automatic pulse_new_game();
    @(posedge clk);
    #1;
    new_game = 1;
    tick(1);
    new_game = 0;
  endtask

  task automatic backdoor(input int a, input int d);
    @(posedge clk);
    #1;
    bd_addr = 6'(a);
    bd_data = 2'(d);
    bd_en = 1;
    tick(1);
    bd_en = 0;
  endtask

  task automatic queue_empty(input string name);
    chk({name, "_pending_events"}, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0; drop = 0; new_game = 0; col_sel = 0;
    bd_en = 0; bd_addr = 0; bd_data = 0;
    cc_enable = 1; go_flag = 0;
    tick(3);
    chk("rst_wren", int'(ram_wren), 0);
    chk("rst_addr", int'(ram_address), 7);
    chk("rst_busy", int'(busy), 1);
    chk("rst_wcheck", int'(winner_check), 0);
    chk("rst_reset_game", int'(reset_game), 0);
    chk("rst_player", int'(player), 1);
    chk("rst_move_count", int'(move_count), 0);
    chk("rst_col_err", int'(col_err), 0);

    // board clear after reset
    push_clear();
    resetn = 1;
    wait_idle("clear");
    queue_empty("clear");
    chk("clear_player", int'(player), 1);
    chk("clear_move_count", int'(move_count), 0);

    // empty board, column 3
    push(K_PR, 45, 0);
    push(K_WR, 45, 1);
    push(K_WC, 3, 0);
    do_drop(3);
    wait_idle("drop3");
    queue_empty("drop3");
    chk("drop3_write_latency", last_wr_cyc - t_drop, 5);
    chk("drop3_player", int'(player), 2);
    chk("drop3_move_count", int'(move_count), 1);
    chk("drop3_mem45", int'(mem[45]), 1);

    // column 0 holding five pieces
    backdoor(42, 1); backdoor(35, 2); backdoor(28, 1);
    backdoor(21, 2); backdoor(14, 1);
    for (int a = 42; a >= 7; a -= 7) push(K_PR, a, 0);
    push(K_WR, 7, 2);
    push(K_WC, 3, 0);
    do_drop(0);
    wait_idle("col0_top");
    queue_empty("col0_top");
    chk("col0_top_player", int'(player), 1);
    chk("col0_top_move_count", int'(move_count), 2);

    // column 0 full, then an out-of-range column
    for (int a = 42; a >= 7; a -= 7) push(K_PR, a, 0);
    push(K_ER, 0, 0);
    do_drop(0);
    wait_idle("col0_full");
    queue_empty("col0_full");
    chk("col0_full_player", int'(player), 1);
    chk("col0_full_move_count", int'(move_count), 2);
    push(K_ER, 0, 0);
    do_drop(7);
    tick(3);
    queue_empty("col7");
    chk("col7_err_latency", last_err_cyc - t_drop, 1);
    chk("col7_busy", int'(busy), 0);

    // game over, drop ignored, new game clears
    go_flag = 1;
    push(K_PR, 43, 0);
    push(K_WR, 43, 1);
    push(K_WC, 3, 0);
    do_drop(1);
    wait_idle("over");
    go_flag = 0;
    queue_empty("over");
    chk("over_player", int'(player), 1);
    chk("over_move_count", int'(move_count), 3);
    do_drop(2);
    tick(8);
    chk("over_drop_busy", int'(busy), 0);
    queue_empty("over_drop");
    push_clear();
    pulse_new_game();
    do_drop(4);
    wait_idle("new_game");
    queue_empty("new_game");
    chk("new_game_player", int'(player), 1);
    chk("new_game_move_count", int'(move_count), 0);
    chk("new_game_mem43", int'(mem[43]), 0);
    chk("new_game_mem7", int'(mem[7]), 0);

    // async reset during PROBE
    do_drop(5);
    @(posedge clk);
    #2;
    resetn = 0;
    #1;
    chk("rst_probe_wcheck", int'(winner_check), 0);
    chk("rst_probe_addr", int'(ram_address), 7);
    chk("rst_probe_wren", int'(ram_wren), 0);
    push_clear();
    tick(2);
    resetn = 1;
    wait_idle("rst_probe");
    queue_empty("rst_probe");

    // async reset during CHECK
    cc_enable = 0;
    push(K_PR, 48, 0);
    push(K_WR, 48, 1);
    do_drop(6);
    begin
      int k;
      k = 0;
      while (!winner_check && k < 60) begin
        tick(1);
        k++;
      end
      chk("wcheck_rise_timeout", int'(winner_check), 1);
    end
    tick(3);
    chk("wcheck_held", int'(winner_check), 1);
    #1;
    resetn = 0;
    #1;
    chk("rst_check_wcheck", int'(winner_check), 0);
    chk("rst_check_addr", int'(ram_address), 7);
    push_clear();
    tick(2);
    resetn = 1;
    cc_enable = 1;
    wait_idle("rst_check");
    queue_empty("rst_check");
    chk("rst_check_mem48", int'(mem[48]), 0);
    chk("rst_check_player", int'(player), 1);
    chk("rst_check_move_count", int'(move_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
